// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
package ifetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch entries with flush; push is accepted
// when full only if a pop happens in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_data,
  output fetch_entry_t               o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC owner and instruction memory requester feeding decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  branch,
  input  logic [WORD_WIDTH-1:0] branch_target,
  input  logic                  stall,
  output logic [WORD_WIDTH-1:0] instr_dec,
  output logic [WORD_WIDTH-1:0] pc_dec,
  output logic                  instr_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t          r_state, w_state_nxt;
  logic [WORD_WIDTH-1:0] r_pc;
  logic [CW-1:0]         r_discard, w_discard_nxt, w_out_nxt;
  logic [CW-1:0]         w_buf_count, w_pcq_count;
  logic                  w_buf_empty, w_buf_full, w_pcq_empty, w_pcq_full;
  logic                  w_grant, w_drop, w_push, w_pop, w_bypass, w_credit;
  fetch_entry_t          w_buf_head, w_pcq_head, w_resp, w_req_entry;
  logic                  w_unused;
  // The in-flight PC queue depth equals the number of outstanding requests.
  assign w_credit    = (w_pcq_count + w_buf_count) < CW'(FIFO_DEPTH);
  assign imem_req    = (r_state != BOOT) & w_credit & ~branch;
  assign imem_addr   = r_pc;
  assign w_grant     = imem_req & imem_gnt;
  assign w_drop      = imem_rvalid & (r_discard != '0);
  assign w_out_nxt   = w_pcq_count + CW'(w_grant) - CW'(imem_rvalid);
  assign w_req_entry = '{instr: '0, pc: r_pc};
  assign w_resp      = '{instr: imem_rdata, pc: w_pcq_head.pc};
`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_buf_empty & (r_discard == '0) & imem_rvalid & ~branch;
`else
  assign w_bypass = 1'b0;
`endif
  assign instr_valid = ~branch & (~w_buf_empty | w_bypass);
  assign instr_dec   = w_bypass ? imem_rdata : w_buf_head.instr;
  assign pc_dec      = w_bypass ? w_pcq_head.pc : w_buf_head.pc;
  assign w_pop       = instr_valid & ~stall & ~w_bypass;
  assign w_push      = imem_rvalid & ~w_drop & ~(w_bypass & ~stall);
  assign w_unused    = ^{w_pcq_empty, w_pcq_full, w_buf_full, w_pcq_head.instr};
  // Branch discards every request still in flight after this cycle.
  assign w_discard_nxt = branch ? w_out_nxt : r_discard - CW'(w_drop);
  always_comb begin
    w_state_nxt = r_state;
    if (branch)
      w_state_nxt = (w_out_nxt != '0) ? DRAIN : FETCH;
    else if (r_state == BOOT)
      w_state_nxt = FETCH;
    else if (r_state == DRAIN)
      w_state_nxt = (w_discard_nxt == '0) ? FETCH : DRAIN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_discard <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      r_pc      <= branch  ? {branch_target[WORD_WIDTH-1:2], 2'b00} :
                   w_grant ? r_pc + WORD_WIDTH'(INSTR_BYTES) : r_pc;
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch),
    .i_data  (w_resp),
    .o_data  (w_buf_head),
    .o_count (w_buf_count),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );
  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_grant),
    .i_pop   (imem_rvalid),
    .i_flush (1'b0),
    .i_data  (w_req_entry),
    .o_data  (w_pcq_head),
    .o_count (w_pcq_count),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized bench comparing ifetch_unit against a request-level model
// that tracks in-flight fetches (marked stale on branch) and the decode-visible word stream.
module tb_ifetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic        clk = 0;
  logic        rstn = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0, branch = 0, stall = 0, instr_valid;
  logic [31:0] imem_addr, imem_rdata = 0, branch_target = 0, instr_dec, pc_dec;

  ifetch_unit #(.WORD_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .stall         (stall),
    .instr_dec     (instr_dec),
    .pc_dec        (pc_dec),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; bit stale;} infl_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
  infl_t       infl[$];
  ent_t        buffer[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;
  bit          m_boot;
  int          n_chk = 0, n_fail = 0;
  int          p_br, p_st, p_gnt, p_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    buffer.delete();
    mem_q.delete();
    m_pc   = RST_PC;
    m_boot = 1;
  endtask

  task automatic drive_idle();
    branch = 0; stall = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; branch_target = 0;
  endtask

  task automatic check_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_dec, 0);
    chk("rst_pc", pc_dec, 0);
  endtask

  // One cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step();
    bit    er, ev, byp;
    ent_t  head;
    infl_t f;
    branch        = $urandom_range(0, 99) < p_br;
    branch_target = $urandom;
    stall         = $urandom_range(0, 99) < p_st;
    imem_gnt      = $urandom_range(0, 99) < p_gnt;
    imem_rvalid   = mem_q.size() > 0 && $urandom_range(0, 99) < p_rv;
    imem_rdata    = imem_rvalid ? mem_q[0] ^ KEY : $urandom;
    #1;
    er  = !m_boot && (infl.size() + buffer.size() < DEPTH) && !branch;
    byp = 0;
`ifdef FETCH_BYPASS_EN
    byp = buffer.size() == 0 && imem_rvalid && infl.size() > 0 && !infl[0].stale && !branch;
`endif
    ev = !branch && (buffer.size() > 0 || byp);
    chk("req", imem_req, er);
    chk("addr", imem_addr, m_pc);
    chk("valid", instr_valid, ev);
    if (ev) begin
      head = byp ? '{infl[0].pc ^ KEY, infl[0].pc} : buffer[0];
      chk("instr", instr_dec, head.instr);
      chk("pc", pc_dec, head.pc);
    end
    if (ev && !stall && !byp) buffer.delete(0);
    if (imem_rvalid && infl.size() > 0) begin
      f = infl.pop_front();
      if (!f.stale && !branch && !(byp && !stall)) buffer.push_back('{f.pc ^ KEY, f.pc});
    end
    if (imem_rvalid) mem_q.delete(0);
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
    if (er && imem_gnt) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc += 32'd4;
    end
    if (branch) begin
      buffer.delete();
      foreach (infl[i]) infl[i].stale = 1;
      m_pc = {branch_target[31:2], 2'b00};
    end
    m_boot = 0;
  endtask

  task automatic run(input int cycles, input int br, input int st, input int gnt, input int rv);
    p_br = br; p_st = st; p_gnt = gnt; p_rv = rv;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rstn = 0;
    drive_idle();
    model_reset();
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rstn = 1;
    p_br = 0; p_st = 0; p_gnt = 100; p_rv = 100;
    step();
  endtask

  initial begin
    drive_idle();
    reset_seq();
    run(20, 0, 0, 100, 100);
    run(40, 0, 80, 100, 100);
    run(30, 0, 0, 40, 70);
    run(1500, 8, 30, 60, 60);
    reset_seq();
    run(400, 15, 20, 70, 80);
    run(300, 3, 50, 50, 40);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
